// File: rtl/inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module  : inv_cipher_iter (+ inv_sub_bytes, inv_shift_rows, inv_mix_columns)
// Brief   : Iterative AES inverse cipher, one round per clock, start/done.
// Revision: 1.0 - initial release
// ============================================================================

module inv_sub_bytes (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
    end
endmodule

module inv_shift_rows (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    // Byte k = row (k%4), column (k/4); byte 0 sits in bits [127:120].
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int SRC = r + 4 * ((c - r + 4) % 4);
            localparam int DST = r + 4 * c;
            assign data_o[127-8*DST -: 8] = data_i[127-8*SRC -: 8];
        end
    end
endmodule

module inv_mix_columns (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(a) ^ a;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[127-32*c -: 8];
        assign a1 = data_i[119-32*c -: 8];
        assign a2 = data_i[111-32*c -: 8];
        assign a3 = data_i[103-32*c -: 8];
        assign data_o[127-32*c -: 8] = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
        assign data_o[119-32*c -: 8] = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
        assign data_o[111-32*c -: 8] = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
        assign data_o[103-32*c -: 8] = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
    end
endmodule

module inv_cipher_iter #(
    parameter int Nk = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [127:0]            cipherText,
    input  logic [(Nk+7)*128-1:0]   keys,
    output logic [127:0]            plainText,
    output logic                    busy,
    output logic                    done
);
    localparam int Nr = Nk + 6;
    localparam int RW = $clog2(Nr + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [127:0]    blk_q, blk_d;
    logic [127:0]    pt_q, pt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Round-key table padded to a power of two so any rnd value selects safely.
    logic [127:0]    rk_w [2**RW];
    logic [RW-1:0]   w_kidx;
    logic [127:0]    w_rk;
    logic [127:0]    w_isr, w_isb, w_ark, w_imc;

    for (genvar i = 0; i < 2**RW; i++) begin : g_rk
        if (i <= Nr) begin : g_key
            assign rk_w[i] = keys[128*i +: 128];
        end else begin : g_pad
            assign rk_w[i] = '0;
        end
    end

    // The initial whitening in IDLE uses the last round key.
    assign w_kidx = (state_q == S_IDLE) ? RW'(Nr) : rnd_q;
    assign w_rk   = rk_w[w_kidx];

    inv_shift_rows  u_isr (.data_i(blk_q), .data_o(w_isr));
    inv_sub_bytes   u_isb (.data_i(w_isr), .data_o(w_isb));
    assign w_ark = w_isb ^ w_rk;
    inv_mix_columns u_imc (.data_i(w_ark), .data_o(w_imc));

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk_d   = cipherText ^ w_rk;
                    rnd_d   = RW'(Nr - 1);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rnd_q == '0) begin
                    pt_d    = w_ark;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    blk_d = w_imc;
                    rnd_d = rnd_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
            pt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign plainText = pt_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

`default_nettype wire

// File: tb/tb_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_inv_cipher_iter
// Brief   : Directed and round-trip bench for inv_cipher_iter (AES-128/192/256).
// Revision: 1.0 - initial release
// ============================================================================
module tb_inv_cipher_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start0, start1, start2;
    logic [127:0]  ct0, ct1, ct2;
    logic [1919:0] keys0, keys1, keys2;
    logic [127:0]  pt0, pt1, pt2;
    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;

    inv_cipher_iter #(.Nk(4)) u_dut128 (.clk(clk), .rst(rst), .start(start0), .cipherText(ct0),
        .keys(keys0[1407:0]), .plainText(pt0), .busy(busy0), .done(done0));
    inv_cipher_iter #(.Nk(6)) u_dut192 (.clk(clk), .rst(rst), .start(start1), .cipherText(ct1),
        .keys(keys1[1663:0]), .plainText(pt1), .busy(busy1), .done(done1));
    inv_cipher_iter #(.Nk(8)) u_dut256 (.clk(clk), .rst(rst), .start(start2), .cipherText(ct2),
        .keys(keys2[1919:0]), .plainText(pt2), .busy(busy2), .done(done2));

    int checks = 0;
    int failures = 0;
    int dcount = 0;

    always @(negedge clk) begin
        if (done0) dcount++;
        if (done1) dcount++;
        if (done2) dcount++;
    end

    // ---------------- reference model (forward cipher + key schedule) -------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        for (int v = 1; v < 256; v++)
            if (gmul(x, 8'(v)) == 8'h01) s = 8'(v);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++)
            r[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    function automatic logic [127:0] encrypt(input int nk, input logic [1919:0] ks, input logic [127:0] p);
        logic [127:0] s, o;
        logic [7:0] a0, a1, a2, a3;
        int nr;
        nr = nk + 6;
        s = p ^ ks[127:0];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int b = 0; b < 16; b++) s[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            s = o;
            if (rd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
                    o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                s = o;
            end
            s ^= ks[128*rd +: 128];
        end
        return s;
    endfunction

    // ---------------- helpers -------------------------------------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic get_done(input int d);
        return (d == 0) ? done0 : (d == 1) ? done1 : done2;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
    endfunction

    function automatic logic [127:0] get_pt(input int d);
        return (d == 0) ? pt0 : (d == 1) ? pt1 : pt2;
    endfunction

    task automatic set_in(input int d, input logic s, input logic [127:0] ct);
        case (d)
            0: begin start0 = s; ct0 = ct; end
            1: begin start1 = s; ct1 = ct; end
            default: begin start2 = s; ct2 = ct; end
        endcase
    endtask

    task automatic set_keys(input int d, input logic [1919:0] k);
        case (d)
            0: keys0 = k;
            1: keys1 = k;
            default: keys2 = k;
        endcase
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input int d, input logic [127:0] ct);
        set_in(d, 1'b1, ct);
        @(negedge clk);
        set_in(d, 1'b0, rand128());
    endtask

    // lat counts edges from the accepting edge (=1) up to the done cycle.
    task automatic wait_done(input int d, output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!get_done(d) && lat < 40) begin
            if (get_busy(d)) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        int           d;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        vec_t vt [3];
        logic [1919:0] ks128, ks;
        logic [127:0] p2, c2, p, c;
        int lat, bc, nd, lat1, late_busy, d, nr, d0cnt;

        vt[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, FIPS_PT};
        vt[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, FIPS_PT};
        vt[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089, FIPS_PT};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(i, 1'b0, '0);
            set_keys(i, '0);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_pt", get_pt(i), '0);
            chk("reset_busy", get_busy(i), 1'b0);
            chk("reset_done", get_done(i), 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 known-answer vectors for all three key lengths
        for (int i = 0; i < 3; i++) begin
            d  = vt[i].d;
            nr = 10 + 2*d;
            ks = expand(4 + 2*d, vt[i].key);
            set_keys(d, ks);
            start_op(d, vt[i].ct);
            chk("busy_after_accept", get_busy(d), 1'b1);
            wait_done(d, lat, bc);
            chk("kat_latency", 128'(lat), 128'(nr + 1));
            chk("kat_plaintext", get_pt(d), vt[i].pt);
            chk("kat_busy_in_done", get_busy(d), 1'b0);
            chk("kat_busy_cycles", 128'(bc), 128'(nr));
            @(negedge clk);
            chk("kat_done_one_cycle", get_done(d), 1'b0);
            chk("kat_pt_held", get_pt(d), vt[i].pt);
        end
        ks128 = expand(4, vt[0].key);
        set_keys(0, ks128);

        // start pulses while busy must be ignored
        set_in(0, 1'b1, vt[0].ct);
        @(negedge clk);
        nd = 0; lat1 = 0; late_busy = 0;
        for (int k = 1; k <= 30; k++) begin
            set_in(0, (k == 3 || k == 7), (k == 3 || k == 7) ? 128'hdeadbeefcafef00d0123456789abcdef : rand128());
            if (done0) begin
                nd++;
                if (lat1 == 0) lat1 = k;
            end
            if (busy0 && k > 11) late_busy++;
            @(negedge clk);
        end
        chk("busy_start_done_count", 128'(nd), 128'd1);
        chk("busy_start_latency", 128'(lat1), 128'd11);
        chk("busy_start_plaintext", pt0, FIPS_PT);
        chk("busy_start_no_second_op", 128'(late_busy), 128'd0);

        // back-to-back: new start in the done cycle
        p2 = 128'h0f0e0d0c0b0a09080706050403020100;
        c2 = encrypt(4, ks128, p2);
        start_op(0, vt[0].ct);
        wait_done(0, lat, bc);
        chk("b2b_first_plaintext", pt0, FIPS_PT);
        start_op(0, c2);
        wait_done(0, lat, bc);
        chk("b2b_gap", 128'(lat), 128'd11);
        chk("b2b_second_plaintext", pt0, p2);
        @(negedge clk);

        // reset mid-operation, with start also high (reset wins)
        start_op(0, vt[0].ct);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        set_in(0, 1'b1, rand128());
        @(negedge clk);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_done", done0, 1'b0);
        chk("abort_pt", pt0, '0);
        rst = 1'b0;
        start_op(0, c2);
        wait_done(0, lat, bc);
        chk("after_abort_latency", 128'(lat), 128'd11);
        chk("after_abort_plaintext", pt0, p2);
        repeat (2) @(negedge clk);

        // random round trips against the reference encryptor
        d0cnt = dcount;
        for (int i = 0; i < 200; i++) begin
            d  = i % 3;
            ks = expand(4 + 2*d, {rand128(), rand128()});
            p  = rand128();
            c  = encrypt(4 + 2*d, ks, p);
            set_keys(d, ks);
            start_op(d, c);
            wait_done(d, lat, bc);
            chk("roundtrip", get_pt(d), p);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("roundtrip_done_count", 128'(dcount - d0cnt), 128'd200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
